// File: rtl/tensor_slice_seq_pkg.sv
// Shared definitions for the tensor_slice sequencer: instruction layout, cfg field
// offsets and FSM state encodings.
package tensor_slice_seq_pkg;

  localparam int CFG_W    = 26;
  localparam int INSTR_W  = 28;
  localparam int TRIG_BIT = 0;
  localparam int OUT_LSB  = 12;  // OSEL/RELU/SHIFT block copied during EMIT
  localparam int OUT_MSB  = 20;
  localparam int PIDX_LSB = 21;

  typedef struct packed {
    logic             emit;
    logic             cons;
    logic [CFG_W-1:0] cfg;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/tensor_slice_seq_prog_mem.sv
// Program store for the sequencer: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module tensor_slice_seq_prog_mem
  import tensor_slice_seq_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int PROG_AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PROG_AW-1:0] waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PROG_AW-1:0] raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tensor_slice_seq.sv
// Microcoded sequencer driving one tensor_slice config word; runs a loaded program
// iter+1 times. Optional stall counter enabled by defining TS_SEQ_PERF_EN.
module tensor_slice_seq
  import tensor_slice_seq_pkg::*;
#(
  parameter int CONFIG_WIDTH = 26,
  parameter int PROG_DEPTH   = 16,
  parameter int PROG_AW      = 4,
  parameter int ITER_WIDTH   = 8,
  parameter int DUMP_IDX     = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prog_we,
  input  logic [PROG_AW-1:0]      prog_addr,
  input  logic [27:0]             prog_wdata,
  input  logic                    start,
  input  logic [PROG_AW-1:0]      last_addr,
  input  logic [ITER_WIDTH-1:0]   iter,
  output logic                    busy,
  output logic                    done,
  input  logic                    wnd_valid,
  output logic                    wnd_ready,
  output logic [CONFIG_WIDTH-1:0] cfg_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             perf_stall
);

  localparam logic [CONFIG_WIDTH-1:0] IDLE_CFG =
    CONFIG_WIDTH'(DUMP_IDX) << PIDX_LSB;

  seq_state_e            state;
  logic [PROG_AW-1:0]    pc;
  logic [PROG_AW-1:0]    last_q;
  logic [ITER_WIDTH-1:0] iter_cnt;
  logic [INSTR_W-1:0]    rd_data;
  instr_t                instr;
  logic                  stall;
  logic                  adv;
  logic                  start_ok;

  tensor_slice_seq_prog_mem #(
    .PROG_DEPTH (PROG_DEPTH),
    .PROG_AW    (PROG_AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (prog_we && !busy),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (pc),
    .rdata (rd_data)
  );

  assign instr    = instr_t'(rd_data);
  assign start_ok = (state == ST_IDLE) && start;

  // Slice-facing outputs follow the current step; non-issue cycles park sp on the dump slot.
  always_comb begin
    cfg_out   = IDLE_CFG;
    wnd_ready = 1'b0;
    stall     = 1'b0;
    adv       = 1'b0;
    case (state)
      ST_ISSUE: begin
        if (instr.cons && !wnd_valid) begin
          stall = 1'b1;
        end else begin
          cfg_out           = instr.cfg;
          cfg_out[TRIG_BIT] = 1'b1;
          wnd_ready         = instr.cons;
          adv               = !instr.emit;
        end
      end
      ST_EMIT: begin
        cfg_out[OUT_MSB:OUT_LSB] = instr.cfg[OUT_MSB:OUT_LSB];
        adv                      = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            last_q   <= last_addr;
            iter_cnt <= iter;
            pc       <= '0;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall && instr.emit) begin
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT:  if (out_ready) out_valid <= 1'b0;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      // Step completion: next step, next pass, or end of run.
      if (adv) begin
        if (pc != last_q) begin
          pc    <= pc + PROG_AW'(1);
          state <= ST_ISSUE;
        end else if (iter_cnt != '0) begin
          iter_cnt <= iter_cnt - ITER_WIDTH'(1);
          pc       <= '0;
          state    <= ST_ISSUE;
        end else begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
      end
    end
  end

`ifdef TS_SEQ_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_q <= '0;
    end else if (stall || ((state == ST_EMIT) && !out_ready)) begin
      perf_q <= sat_inc16(perf_q);
    end
  end

  assign perf_stall = perf_q;
`else
  assign perf_stall = '0;
`endif

endmodule
